serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: c_in  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high while an addition is in progress (RUN state).
REQ-009 Port: done  output  1  single-cycle pulse marking sum/c_out valid.
REQ-010 Port: sum  output  WIDTH  result; holds its value from done until the next accepted start.
REQ-011 Port: c_out  output  1  final carry; same hold rule as sum.

Function
REQ-012 The block SHALL add a, b and c_in bit-serially, LSB first, one bit per clock, through a single 1-bit full adder.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, the block SHALL load a, b and c_in into the A shift register, the B shift register and the carry flop; clear the bit counter; and move to RUN on the same edge.
REQ-015 In RUN, each edge SHALL shift A and B right by one, shift the full-adder sum bit into the sum register MSB (sum shifts right), register the full-adder carry, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge that completes bit WIDTH-1 the FSM SHALL enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle and c_out SHALL equal the registered carry; the FSM SHALL then return to IDLE unconditionally.
REQ-018 Latency: done SHALL assert WIDTH+1 cycles after the edge that accepted start.
REQ-019 Result: {c_out, sum} SHALL equal a + b + c_in, computed at WIDTH+1 bits with no truncation.
REQ-020 start asserted in RUN or DONE SHALL be ignored, with no queuing; operand changes after acceptance SHALL NOT affect the result.
REQ-021 start held high continuously SHALL yield back-to-back operations: one accepted start every WIDTH+2 cycles.
REQ-022 busy SHALL be 1 only in RUN; done and busy SHALL never be high together.
REQ-023 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap during an operation.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, c_out=0, counter=0, shift registers=0 and carry=0.
REQ-025 Reset mid-RUN SHALL abort the operation with no done pulse; the first start accepted after rst_n rises SHALL complete normally.
REQ-026 Release of rst_n SHALL be synchronised externally; the block has no internal reset synchroniser.

Structure
REQ-027 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared package, serial_adder_pkg; WIDTH SHALL stay a module parameter.
REQ-028 The 1-bit adder SHALL be an instance of the existing fulladder module (ports a, b, c_in, s, c); no other sub-modules.

Verification
REQ-029 WIDTH=8, a=8'h0F, b=8'h01, c_in=0, start one cycle -> busy for 8 cycles, done at cycle 9, sum=8'h10, c_out=0.
REQ-030 a=8'hFF, b=8'h01, c_in=1 -> sum=8'h01, c_out=1; a=b=8'h00, c_in=0 -> sum=8'h00, c_out=0.
REQ-031 start pulsed again during RUN, with a and b changed to 8'hAA -> first result unaffected, exactly one done pulse.
REQ-032 rst_n=0 at RUN cycle 4 -> busy, done, sum and c_out all 0 immediately, no done pulse; next operation 8'h55+8'hAA+1 -> sum=8'h00, c_out=1.
REQ-033 start held high for three operations -> done every 10 cycles, each result correct.
REQ-034 Exhaustive check at WIDTH=4 (all a, b, c_in) against a reference model of a+b+c_in -> zero mismatches.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder.
//   state_t      : FSM state encoding (IDLE, RUN, DONE)
//   counterWidth : width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    // The counter has one bit more than $clog2(width). It can therefore count
    // up to width itself and never wraps inside an operation.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    function automatic int counterWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
// Single-bit full adder. Combinational only.
//   a, b, c_in : addend bits and carry in
//   s          : sum bit
//   c          : carry out
// -----------------------------------------------------------------------------
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c
);

    // Sum is the parity of the three inputs. The carry is generated when
    // both addend bits are set, or propagated when exactly one is set.
    assign s = a ^ b ^ c_in;
    assign c = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Adds two WIDTH-bit operands and a carry-in bit-serially, LSB first, with one
// 1-bit full adder. Each clock of the RUN state processes one bit.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (the release is synchronised
//            outside this block)
//   start  : begin an addition; looked at only in IDLE
//   a, b   : operands, captured when start is accepted
//   c_in   : carry-in, captured when start is accepted
//   busy   : high while bits are being processed (RUN)
//   done   : one-cycle pulse; sum/c_out are valid
//   sum    : result; holds from done until the next accepted start
//   c_out  : final carry; same hold behaviour as sum
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int                CNT_W    = counterWidth(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_shiftA;
    logic [WIDTH-1:0]   r_shiftB;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_count;
    logic               w_sumBit;
    logic               w_carryBit;

    // The single full adder always works on the current LSBs of the operand
    // shift registers and the running carry.
    fulladder u_fullAdder (
        .a    (r_shiftA[0]),
        .b    (r_shiftB[0]),
        .c_in (r_carry),
        .s    (w_sumBit),
        .c    (w_carryBit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN exits on the edge that consumes bit WIDTH-1.
    // DONE lasts exactly one cycle, so start is ignored everywhere except IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = RUN;
            RUN:     if (r_count == LAST_BIT) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath. Operands load only on an accepted start. In RUN, each edge
    // shifts the new sum bit into the sum MSB, so after WIDTH edges the LSB
    // of the result sits at bit 0. The datapath holds in DONE and IDLE, and
    // that keeps sum and c_out stable until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shiftA <= '0;
            r_shiftB <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shiftA <= a;
                        r_shiftB <= b;
                        r_sum    <= '0;
                        r_carry  <= c_in;
                        r_count  <= '0;
                    end
                end
                RUN: begin
                    r_shiftA <= r_shiftA >> 1;
                    r_shiftB <= r_shiftB >> 1;
                    r_sum    <= {w_sumBit, r_sum[WIDTH-1:1]};
                    r_carry  <= w_carryBit;
                    r_count  <= r_count + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);
    assign sum   = r_sum;
    assign c_out = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder. It uses one 8-bit instance for the
// directed and random scenarios, and one 4-bit instance for the full sweep of
// inputs. Expected results come from plain arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int testsRun;
    int testsFailed;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .c_in  (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .c_out (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .c_in  (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .c_out (cout4)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one 8-bit addition. The task starts and ends on a falling edge.
    // Cycle 1 is the first falling edge after the accepting rising edge.
    // With disturb set, the task pulses start and changes both operands to
    // 8'hAA in the middle of RUN.
    task automatic applyStimulus(input logic [7:0] aIn, input logic [7:0] bIn,
                                 input logic cIn, input bit disturb, input string tag);
        logic [8:0] expected;
        int         doneCycle;
        int         busyCycles;
        int         doneCount;
        int         overlap;
        expected   = 9'(aIn) + 9'(bIn) + 9'(cIn);
        doneCycle  = 0;
        busyCycles = 0;
        doneCount  = 0;
        overlap    = 0;
        a8     = aIn;
        b8     = bIn;
        cin8   = cIn;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (busy8) busyCycles++;
            if (busy8 && done8) overlap++;
            if (done8) begin
                doneCount++;
                if (doneCycle == 0) begin
                    doneCycle = cyc;
                    checkOutput({tag, "_result"}, 32'({cout8, sum8}), 32'(expected));
                end
            end
            if (disturb && cyc == 3) begin
                start8 = 1'b1;
                a8     = 8'hAA;
                b8     = 8'hAA;
            end
            if (disturb && cyc == 4) start8 = 1'b0;
        end
        checkOutput({tag, "_latency"}, 32'(doneCycle), 32'd9);
        checkOutput({tag, "_busyCycles"}, 32'(busyCycles), 32'd8);
        checkOutput({tag, "_donePulses"}, 32'(doneCount), 32'd1);
        checkOutput({tag, "_busyDoneOverlap"}, 32'(overlap), 32'd0);
        checkOutput({tag, "_hold"}, 32'({cout8, sum8}), 32'(expected));
    endtask

    // Runs one 4-bit addition and checks the result and the latency. After
    // done, the task waits one more cycle so that the adder is back in IDLE.
    task automatic runOp4(input logic [3:0] aIn, input logic [3:0] bIn, input logic cIn);
        logic [4:0] expected;
        int         doneCycle;
        expected  = 5'(aIn) + 5'(bIn) + 5'(cIn);
        doneCycle = 0;
        a4     = aIn;
        b4     = bIn;
        cin4   = cIn;
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (done4) begin
                doneCycle = cyc;
                checkOutput("w4_result", 32'({cout4, sum4}), 32'(expected));
                break;
            end
        end
        checkOutput("w4_latency", 32'(doneCycle), 32'd5);
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] expQ[$];
        logic [8:0] expected;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        int         doneCount;
        int         lastDone;

        testsRun    = 0;
        testsFailed = 0;
        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        cin4   = 1'b0;

        // Output values while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy8), 32'd0);
        checkOutput("reset_done", 32'(done8), 32'd0);
        checkOutput("reset_sum", 32'(sum8), 32'd0);
        checkOutput("reset_cout", 32'(cout8), 32'd0);
        checkOutput("reset_w4", 32'({busy4, done4, cout4, sum4}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, "0F_01_0");
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0, "FF_01_1");
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, "00_00_0");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, "FF_FF_1");

        // A start during RUN, with new operands, has no effect.
        applyStimulus(8'h12, 8'h34, 1'b1, 1'b1, "ignoreStart");

        // Reset in the middle of RUN.
        a8     = 8'hFF;
        b8     = 8'hFF;
        cin8   = 1'b1;
        start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrun_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy8), 32'd0);
        checkOutput("abort_done", 32'(done8), 32'd0);
        checkOutput("abort_sum", 32'(sum8), 32'd0);
        checkOutput("abort_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done8) doneCount++;
        end
        checkOutput("abort_noDone", 32'(doneCount), 32'd0);
        applyStimulus(8'h55, 8'hAA, 1'b1, 1'b0, "afterReset");

        // Start held high: one operation every WIDTH+2 cycles.
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        expQ.push_back(9'(ra) + 9'(rb) + 9'(rc));
        a8     = ra;
        b8     = rb;
        cin8   = rc;
        start8 = 1'b1;
        doneCount = 0;
        lastDone  = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (done8) begin
                doneCount++;
                if (expQ.size() > 0) begin
                    expected = expQ.pop_front();
                    checkOutput("b2b_result", 32'({cout8, sum8}), 32'(expected));
                end else begin
                    checkOutput("b2b_extraDone", 32'd1, 32'd0);
                end
                if (doneCount == 1) checkOutput("b2b_firstDone", 32'(cyc), 32'd9);
                else checkOutput("b2b_period", 32'(cyc - lastDone), 32'd10);
                lastDone = cyc;
                if (doneCount < 3) begin
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    rc = 1'($urandom);
                    expQ.push_back(9'(ra) + 9'(rb) + 9'(rc));
                    a8   = ra;
                    b8   = rb;
                    cin8 = rc;
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        checkOutput("b2b_doneCount", 32'(doneCount), 32'd3);
        @(negedge clk);

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random");
        end

        // Every input combination at WIDTH=4.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    runOp4(4'(ia), 4'(ib), 1'(ic));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
